// File: rtl/iso7816_pkg.sv
// Shared types and constants for the ISO7816-3 answer-to-reset path.
package iso7816_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TS,
        ST_T0,
        ST_IFACE,
        ST_HIST,
        ST_TCK,
        ST_DONE,
        ST_ERROR
    } atr_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BAD_TS   = 2'd1,
        ERR_TCK      = 2'd2,
        ERR_OVERLONG = 2'd3
    } atr_err_e;

    localparam logic [7:0]  TS_DIRECT     = 8'h3B;
    localparam logic [7:0]  TS_INVERSE    = 8'h3F;
    localparam logic [7:0]  FIDI_DEFAULT  = 8'h11;
    localparam logic [7:0]  GUARD_DEFAULT = 8'h00;
    localparam logic [7:0]  WI_DEFAULT    = 8'h0A;
    localparam int unsigned ATR_MAX_BYTES = 33;

    // Y bits are ordered TA, TB, TC, TD from bit 0; the lowest set bit is the next character.
    function automatic logic [3:0] next_iface_char(input logic [3:0] y);
        return y & (~y + 4'd1);
    endfunction

endpackage

// File: rtl/iso7816_atr_parser.sv
// Answer-To-Reset decoder: walks TS/T0/interface/historical/TCK characters
// and publishes the negotiated parameter fields for the PPS and protocol engines.
module iso7816_atr_parser
    import iso7816_pkg::*;
#(
    parameter int unsigned MAX_ATR_BYTES = ATR_MAX_BYTES
) (
    input  logic        nReset,
    input  logic        comClk,
    input  logic        start,
    input  logic        rxByteValid,
    input  logic [7:0]  rxByte,
    output logic        busy,
    output logic        atrDone,
    output logic        atrError,
    output logic [1:0]  errCode,
    output logic        indirectConvention,
    output logic [7:0]  ta1,
    output logic [7:0]  tc1,
    output logic [7:0]  tc2,
    output logic        ta2Present,
    output logic [15:0] protocolMask,
    output logic [3:0]  histLen,
    output logic        tckRequired,
    output logic [5:0]  byteCount
);

    localparam logic [5:0] CNT_LIMIT = 6'(MAX_ATR_BYTES);
    localparam logic [5:0] CNT_SAT   = 6'(MAX_ATR_BYTES + 1);

    atr_state_e  state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  errCode_q, errCode_d;
    logic        indirect_q, indirect_d;
    logic [7:0]  ta1_q, ta1_d;
    logic [7:0]  tc1_q, tc1_d;
    logic [7:0]  tc2_q, tc2_d;
    logic        ta2Present_q, ta2Present_d;
    logic [15:0] protoMask_q, protoMask_d;
    logic [3:0]  histLen_q, histLen_d;
    logic        tckReq_q, tckReq_d;
    logic [5:0]  byteCount_q, byteCount_d;
    logic [3:0]  y_q, y_d;
    logic [3:0]  level_q, level_d;
    logic [3:0]  histCnt_q, histCnt_d;
    logic [7:0]  xor_q, xor_d;
    logic        tdSeen_q, tdSeen_d;

    logic        parsing;
    logic        leaveIface;
    logic [3:0]  sel;

    assign parsing = (state_q == ST_TS) || (state_q == ST_T0) || (state_q == ST_IFACE) ||
                     (state_q == ST_HIST) || (state_q == ST_TCK);

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        errCode_d    = errCode_q;
        indirect_d   = indirect_q;
        ta1_d        = ta1_q;
        tc1_d        = tc1_q;
        tc2_d        = tc2_q;
        ta2Present_d = ta2Present_q;
        protoMask_d  = protoMask_q;
        histLen_d    = histLen_q;
        tckReq_d     = tckReq_q;
        byteCount_d  = byteCount_q;
        y_d          = y_q;
        level_d      = level_q;
        histCnt_d    = histCnt_q;
        xor_d        = xor_q;
        tdSeen_d     = tdSeen_q;
        leaveIface   = 1'b0;
        sel          = next_iface_char(y_q);

        if (start) begin
            state_d      = ST_TS;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            err_d        = 1'b0;
            errCode_d    = ERR_NONE;
            indirect_d   = 1'b0;
            ta1_d        = FIDI_DEFAULT;
            tc1_d        = GUARD_DEFAULT;
            tc2_d        = WI_DEFAULT;
            ta2Present_d = 1'b0;
            protoMask_d  = '0;
            histLen_d    = '0;
            tckReq_d     = 1'b0;
            byteCount_d  = '0;
            y_d          = '0;
            level_d      = '0;
            histCnt_d    = '0;
            xor_d        = '0;
            tdSeen_d     = 1'b0;
        end else if (rxByteValid && parsing) begin
            if (byteCount_q != CNT_SAT)
                byteCount_d = byteCount_q + 6'd1;
            if (state_q != ST_TS)
                xor_d = xor_q ^ rxByte;

            if (byteCount_q == CNT_LIMIT) begin
                state_d   = ST_ERROR;
                err_d     = 1'b1;
                busy_d    = 1'b0;
                errCode_d = ERR_OVERLONG;
            end else begin
                case (state_q)
                    ST_TS: begin
                        if (rxByte == TS_DIRECT) begin
                            state_d = ST_T0;
                        end else if (rxByte == TS_INVERSE) begin
                            state_d    = ST_T0;
                            indirect_d = 1'b1;
                        end else begin
                            state_d   = ST_ERROR;
                            err_d     = 1'b1;
                            busy_d    = 1'b0;
                            errCode_d = ERR_BAD_TS;
                        end
                    end
                    ST_T0: begin
                        histLen_d = rxByte[3:0];
                        y_d       = rxByte[7:4];
                        level_d   = 4'd1;
                        histCnt_d = '0;
                        if (rxByte[7:4] == 4'd0)
                            leaveIface = 1'b1;
                        else
                            state_d = ST_IFACE;
                    end
                    ST_IFACE: begin
                        y_d = y_q & ~sel;
                        if (sel[0]) begin
                            if (level_q == 4'd1) ta1_d = rxByte;
                            if (level_q == 4'd2) ta2Present_d = 1'b1;
                        end
                        if (sel[2]) begin
                            if (level_q == 4'd1) tc1_d = rxByte;
                            if (level_q == 4'd2) tc2_d = rxByte;
                        end
                        // TD reloads Y from its own high nibble, so the level advances here
                        if (sel[3]) begin
                            y_d      = rxByte[7:4];
                            tdSeen_d = 1'b1;
                            protoMask_d[rxByte[3:0]] = 1'b1;
                            if (rxByte[3:0] != 4'd0) tckReq_d = 1'b1;
                            if (level_q != 4'hF) level_d = level_q + 4'd1;
                        end
                        if (y_d == 4'd0)
                            leaveIface = 1'b1;
                    end
                    ST_HIST: begin
                        histCnt_d = histCnt_q + 4'd1;
                        if (histCnt_d == histLen_q) begin
                            if (tckReq_q) begin
                                state_d = ST_TCK;
                            end else begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                                if (!tdSeen_q) protoMask_d = 16'h0001;
                            end
                        end
                    end
                    ST_TCK: begin
                        busy_d = 1'b0;
                        if ((xor_q ^ rxByte) == 8'h00) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = ST_ERROR;
                            err_d     = 1'b1;
                            errCode_d = ERR_TCK;
                        end
                    end
                    default: ;
                endcase

                if (leaveIface) begin
                    if (histLen_d != 4'd0) begin
                        state_d = ST_HIST;
                    end else if (tckReq_d) begin
                        state_d = ST_TCK;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        if (!tdSeen_d) protoMask_d = 16'h0001;
                    end
                end
            end
        end
    end

    always_ff @(posedge comClk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            errCode_q    <= ERR_NONE;
            indirect_q   <= 1'b0;
            ta1_q        <= FIDI_DEFAULT;
            tc1_q        <= GUARD_DEFAULT;
            tc2_q        <= WI_DEFAULT;
            ta2Present_q <= 1'b0;
            protoMask_q  <= '0;
            histLen_q    <= '0;
            tckReq_q     <= 1'b0;
            byteCount_q  <= '0;
            y_q          <= '0;
            level_q      <= '0;
            histCnt_q    <= '0;
            xor_q        <= '0;
            tdSeen_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            errCode_q    <= errCode_d;
            indirect_q   <= indirect_d;
            ta1_q        <= ta1_d;
            tc1_q        <= tc1_d;
            tc2_q        <= tc2_d;
            ta2Present_q <= ta2Present_d;
            protoMask_q  <= protoMask_d;
            histLen_q    <= histLen_d;
            tckReq_q     <= tckReq_d;
            byteCount_q  <= byteCount_d;
            y_q          <= y_d;
            level_q      <= level_d;
            histCnt_q    <= histCnt_d;
            xor_q        <= xor_d;
            tdSeen_q     <= tdSeen_d;
        end
    end

    assign busy               = busy_q;
    assign atrDone            = done_q;
    assign atrError           = err_q;
    assign errCode            = errCode_q;
    assign indirectConvention = indirect_q;
    assign ta1                = ta1_q;
    assign tc1                = tc1_q;
    assign tc2                = tc2_q;
    assign ta2Present         = ta2Present_q;
    assign protocolMask       = protoMask_q;
    assign histLen            = histLen_q;
    assign tckRequired        = tckReq_q;
    assign byteCount          = byteCount_q;

endmodule

// File: tb/tb_iso7816_atr_parser.sv
// Directed bench for the ATR parser: hand-computed ATR sequences checked with immediate assertions.
module tb_iso7816_atr_parser;

    logic        nReset;
    logic        comClk;
    logic        start;
    logic        rxByteValid;
    logic [7:0]  rxByte;
    logic        busy;
    logic        atrDone;
    logic        atrError;
    logic [1:0]  errCode;
    logic        indirectConvention;
    logic [7:0]  ta1;
    logic [7:0]  tc1;
    logic [7:0]  tc2;
    logic        ta2Present;
    logic [15:0] protocolMask;
    logic [3:0]  histLen;
    logic        tckRequired;
    logic [5:0]  byteCount;

    int unsigned nCmp;
    int unsigned nErr;

    iso7816_atr_parser #(.MAX_ATR_BYTES(33)) dut (
        .nReset             (nReset),
        .comClk             (comClk),
        .start              (start),
        .rxByteValid        (rxByteValid),
        .rxByte             (rxByte),
        .busy               (busy),
        .atrDone            (atrDone),
        .atrError           (atrError),
        .errCode            (errCode),
        .indirectConvention (indirectConvention),
        .ta1                (ta1),
        .tc1                (tc1),
        .tc2                (tc2),
        .ta2Present         (ta2Present),
        .protocolMask       (protocolMask),
        .histLen            (histLen),
        .tckRequired        (tckRequired),
        .byteCount          (byteCount)
    );

    initial comClk = 1'b0;
    always #5 comClk = ~comClk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the following falling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge comClk);
        rxByteValid = 1'b1;
        rxByte      = b;
        @(negedge comClk);
        rxByteValid = 1'b0;
        rxByte      = 8'h00;
    endtask

    task automatic pulse_start();
        @(negedge comClk);
        start = 1'b1;
        @(negedge comClk);
        start = 1'b0;
    endtask

    initial begin
        nCmp        = 0;
        nErr        = 0;
        nReset      = 1'b0;
        start       = 1'b0;
        rxByteValid = 1'b0;
        rxByte      = 8'h00;
        #12;

        // Reset values
        chk("rst_busy",  16'(busy), 16'h0);
        chk("rst_done",  16'(atrDone), 16'h0);
        chk("rst_err",   16'(atrError), 16'h0);
        chk("rst_code",  16'(errCode), 16'h0);
        chk("rst_ta1",   16'(ta1), 16'h0011);
        chk("rst_tc1",   16'(tc1), 16'h0000);
        chk("rst_tc2",   16'(tc2), 16'h000A);
        chk("rst_mask",  protocolMask, 16'h0000);
        chk("rst_bc",    16'(byteCount), 16'h0);
        chk("rst_ind",   16'(indirectConvention), 16'h0);
        @(negedge comClk);
        nReset = 1'b1;

        // IDLE ignores bytes
        send_byte(8'h3B);
        chk("idle_bc",   16'(byteCount), 16'h0);
        chk("idle_busy", 16'(busy), 16'h0);

        // Minimal ATR: 3B 00
        pulse_start();
        chk("t1_busy_armed", 16'(busy), 16'h1);
        send_byte(8'h3B);
        send_byte(8'h00);
        chk("t1_done",  16'(atrDone), 16'h1);
        chk("t1_hist",  16'(histLen), 16'h0);
        chk("t1_ta1",   16'(ta1), 16'h0011);
        chk("t1_mask",  protocolMask, 16'h0001);
        chk("t1_tck",   16'(tckRequired), 16'h0);
        chk("t1_bc",    16'(byteCount), 16'd2);
        chk("t1_busy",  16'(busy), 16'h0);

        // TA1 + TD1(T=1) + TCK: 90^18^01^89 = 00
        pulse_start();
        send_byte(8'h3B);
        send_byte(8'h90);
        send_byte(8'h18);
        send_byte(8'h01);
        chk("t2_busy_pre", 16'(busy), 16'h1);
        send_byte(8'h89);
        chk("t2_done",  16'(atrDone), 16'h1);
        chk("t2_err",   16'(atrError), 16'h0);
        chk("t2_ta1",   16'(ta1), 16'h0018);
        chk("t2_mask",  protocolMask, 16'h0002);
        chk("t2_tck",   16'(tckRequired), 16'h1);
        chk("t2_bc",    16'(byteCount), 16'd5);

        // Wrong TCK
        pulse_start();
        send_byte(8'h3B);
        send_byte(8'h90);
        send_byte(8'h18);
        send_byte(8'h01);
        send_byte(8'h88);
        chk("t3_err",   16'(atrError), 16'h1);
        chk("t3_code",  16'(errCode), 16'd2);
        chk("t3_done",  16'(atrDone), 16'h0);

        // Bad TS, later bytes ignored
        pulse_start();
        send_byte(8'h3A);
        chk("t4_err",   16'(atrError), 16'h1);
        chk("t4_code",  16'(errCode), 16'd1);
        chk("t4_bc",    16'(byteCount), 16'd1);
        send_byte(8'h3B);
        send_byte(8'h00);
        chk("t4_bc_frozen", 16'(byteCount), 16'd1);
        chk("t4_done",  16'(atrDone), 16'h0);
        chk("t4_code2", 16'(errCode), 16'd1);

        // Overlong: 3F 8F then TD chain of 80s, 34th byte errors
        pulse_start();
        send_byte(8'h3F);
        send_byte(8'h8F);
        for (int i = 0; i < 31; i++) send_byte(8'h80);
        chk("t5_bc33",   16'(byteCount), 16'd33);
        chk("t5_busy33", 16'(busy), 16'h1);
        chk("t5_err33",  16'(atrError), 16'h0);
        send_byte(8'h80);
        chk("t5_err",    16'(atrError), 16'h1);
        chk("t5_code",   16'(errCode), 16'd3);
        chk("t5_ind",    16'(indirectConvention), 16'h1);
        chk("t5_bc34",   16'(byteCount), 16'd34);
        chk("t5_mask",   protocolMask, 16'h0001);
        send_byte(8'h80);
        chk("t5_bc_sat", 16'(byteCount), 16'd34);

        // TA1 + TC1 + two historical bytes, no TCK
        pulse_start();
        send_byte(8'h3B);
        send_byte(8'h52);
        send_byte(8'h96);
        send_byte(8'h05);
        send_byte(8'h41);
        chk("t6_busy_hist", 16'(busy), 16'h1);
        send_byte(8'h42);
        chk("t6_done",  16'(atrDone), 16'h1);
        chk("t6_ta1",   16'(ta1), 16'h0096);
        chk("t6_tc1",   16'(tc1), 16'h0005);
        chk("t6_hist",  16'(histLen), 16'd2);
        chk("t6_bc",    16'(byteCount), 16'd6);
        chk("t6_mask",  protocolMask, 16'h0001);

        // TD1(T=0) announcing TA2 + TC2
        pulse_start();
        send_byte(8'h3B);
        send_byte(8'h80);
        send_byte(8'h50);
        send_byte(8'h10);
        send_byte(8'h20);
        chk("t7_done",  16'(atrDone), 16'h1);
        chk("t7_ta2",   16'(ta2Present), 16'h1);
        chk("t7_tc2",   16'(tc2), 16'h0020);
        chk("t7_ta1",   16'(ta1), 16'h0011);
        chk("t7_tck",   16'(tckRequired), 16'h0);
        chk("t7_bc",    16'(byteCount), 16'd5);

        // start coincident with a byte: byte dropped, fields cleared, rearmed
        pulse_start();
        send_byte(8'h3B);
        send_byte(8'h90);
        @(negedge comClk);
        start       = 1'b1;
        rxByteValid = 1'b1;
        rxByte      = 8'h18;
        @(negedge comClk);
        start       = 1'b0;
        rxByteValid = 1'b0;
        rxByte      = 8'h00;
        chk("t8_busy",  16'(busy), 16'h1);
        chk("t8_bc",    16'(byteCount), 16'd0);
        chk("t8_ta1",   16'(ta1), 16'h0011);
        chk("t8_hist",  16'(histLen), 16'h0);
        chk("t8_done",  16'(atrDone), 16'h0);
        send_byte(8'h3B);
        send_byte(8'h00);
        chk("t8_done2", 16'(atrDone), 16'h1);
        chk("t8_bc2",   16'(byteCount), 16'd2);

        // Asynchronous reset mid-ATR
        pulse_start();
        send_byte(8'h3F);
        chk("t9_ind_pre", 16'(indirectConvention), 16'h1);
        #2;
        nReset = 1'b0;
        #1;
        chk("t9_busy",  16'(busy), 16'h0);
        chk("t9_ind",   16'(indirectConvention), 16'h0);
        chk("t9_bc",    16'(byteCount), 16'h0);
        @(negedge comClk);
        nReset = 1'b1;
        @(negedge comClk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
